// File: rtl/async_fifo_pkg.sv
// Shared async-FIFO pointer types and codec helpers (write side, read side, sync bench).
// Latency: pure functions, no state.
// Backpressure: not applicable.
package async_fifo_pkg;

    typedef enum logic {
        PTR_GRAY = 1'b0,
        PTR_BIN  = 1'b1
    } ptr_code_e;

    // Helpers work on a 32-bit container; callers zero-extend narrower pointers
    // and cast the result back, so one definition serves every pointer width.
    localparam int PTR_FN_W = 32;

    function automatic logic [PTR_FN_W-1:0] bin2gray(input logic [PTR_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB; zero upper bits leave narrow codes unaffected.
    function automatic logic [PTR_FN_W-1:0] gray2bin(input logic [PTR_FN_W-1:0] g);
        logic [PTR_FN_W-1:0] b;
        b[PTR_FN_W-1] = g[PTR_FN_W-1];
        for (int i = PTR_FN_W - 2; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [PTR_FN_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < PTR_FN_W; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/fifo_wptr_ctrl_if.sv
// Write-side bundle between producer/synchronizer and the write-pointer controller.
// Latency: wires only.
// Backpressure: w_ready_o gates w_valid_i; master drives requests and synced read pointer.
interface fifo_wptr_ctrl_if #(
    parameter int ADDR_W    = 3,
    parameter int ERR_CNT_W = 16
);
    logic                 w_valid_i;
    logic                 w_ready_o;
    logic                 mem_we_o;
    logic [ADDR_W-1:0]    mem_waddr_o;
    logic [ADDR_W:0]      w_ptr_o;
    logic [ADDR_W:0]      r_ptr_sync_i;
    logic [ADDR_W:0]      w_level_o;
    logic                 w_full_o;
    logic                 w_almost_full_o;
    logic                 w_overflow_o;
    logic                 w_ptr_err_o;
    logic [ERR_CNT_W-1:0] w_err_cnt_o;

    modport master (
        output w_valid_i, r_ptr_sync_i,
        input  w_ready_o, mem_we_o, mem_waddr_o, w_ptr_o, w_level_o,
               w_full_o, w_almost_full_o, w_overflow_o, w_ptr_err_o, w_err_cnt_o
    );

    modport slave (
        input  w_valid_i, r_ptr_sync_i,
        output w_ready_o, mem_we_o, mem_waddr_o, w_ptr_o, w_level_o,
               w_full_o, w_almost_full_o, w_overflow_o, w_ptr_err_o, w_err_cnt_o
    );
endinterface

// File: rtl/fifo_wptr_ctrl.sv
// Async FIFO write-side pointer/flag controller with crossing-corruption detection.
// Latency: mem write same cycle as accept; pointer, level and flags one cycle later.
// Backpressure: w_ready_o = !full (registered); writes while full are dropped and pulse overflow.
module fifo_wptr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int        ADDR_W        = 3,
    parameter ptr_code_e PTR_CODE      = PTR_GRAY,
    parameter int        AFULL_TH      = (1 << ADDR_W) - 2,
    parameter int        CHECK_HAMMING = 1,
    parameter int        ERR_CNT_W     = 16
) (
    input  logic              w_clk_i,
    input  logic              w_rstn_i,
    fifo_wptr_ctrl_if.slave   bus
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_P = PTR_W'(AFULL_TH);

    logic [PTR_W-1:0]     wbin_q, wbin_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     level_q, level_d;
    logic [PTR_W-1:0]     rprev_q;
    logic [PTR_W-1:0]     rbin;
    logic [PTR_W-1:0]     level_raw;
    logic                 full_q, full_d;
    logic                 afull_q, afull_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 accept;
    logic                 ham_err;
    logic                 err_evt;

    // Next-state: advance pointer on accept, derive level/flags against the synced read pointer.
    always_comb begin
        accept  = bus.w_valid_i && !full_q;
        wbin_d  = accept ? wbin_q + PTR_W'(1) : wbin_q;
        wptr_d  = (PTR_CODE == PTR_GRAY) ? PTR_W'(bin2gray(PTR_FN_W'(wbin_d))) : wbin_d;
        rbin    = (PTR_CODE == PTR_GRAY) ? PTR_W'(gray2bin(PTR_FN_W'(bus.r_ptr_sync_i)))
                                         : bus.r_ptr_sync_i;
        // Using the post-accept write pointer keeps full pessimistic on the accepting edge.
        level_raw = wbin_d - rbin;
        level_d   = (level_raw > DEPTH_P) ? DEPTH_P : level_raw;
        full_d    = (level_raw >= DEPTH_P);
        afull_d   = (level_raw >= AFULL_P);
        ovf_d     = bus.w_valid_i && full_q;
        // A legal gray crossing moves at most one bit per write-clock sample.
        ham_err   = (PTR_CODE == PTR_GRAY) && (CHECK_HAMMING != 0) &&
                    (popcount(PTR_FN_W'(bus.r_ptr_sync_i ^ rprev_q)) > 32'd1);
        err_evt   = (level_raw > DEPTH_P) || ham_err;
        err_d     = err_q || err_evt;
        cnt_d     = (err_evt && (cnt_q != '1)) ? cnt_q + ERR_CNT_W'(1) : cnt_q;
    end

    // State and registered outputs; async active-low reset clears everything.
    always_ff @(posedge w_clk_i or negedge w_rstn_i) begin
        if (!w_rstn_i) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
            rprev_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
            rprev_q <= bus.r_ptr_sync_i;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // The synchronizer sees w_ptr_o straight from a flop, so no combinational glitches cross.
    assign bus.w_ready_o       = !full_q;
    assign bus.mem_we_o        = accept;
    assign bus.mem_waddr_o     = wbin_q[ADDR_W-1:0];
    assign bus.w_ptr_o         = wptr_q;
    assign bus.w_level_o       = level_q;
    assign bus.w_full_o        = full_q;
    assign bus.w_almost_full_o = afull_q;
    assign bus.w_overflow_o    = ovf_q;
    assign bus.w_ptr_err_o     = err_q;
    assign bus.w_err_cnt_o     = cnt_q;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Directed bench for fifo_wptr_ctrl: gray instance (flow, wrap, corruption) and binary instance.
// Stimulus pushes the expected observation per cycle; a monitor compares at the falling edge.
// Inputs change 1 time unit after the rising edge.
module tb_fifo_wptr_ctrl;
    import async_fifo_pkg::*;

    typedef struct packed {
        logic        rdy;
        logic        we;
        logic [2:0]  waddr;
        logic [3:0]  ptr;
        logic [3:0]  lvl;
        logic        full;
        logic        af;
        logic        ovf;
        logic        err;
        logic [15:0] cnt;
    } obs_t;

    typedef struct {
        bit    dut;
        string name;
        obs_t  exp;
    } item_t;

    logic clk;
    logic rstn_a;
    logic rstn_b;
    item_t q[$];
    int total;
    int bad;
    // 4-bit gray code table, index = binary value.
    int G[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    fifo_wptr_ctrl_if #(.ADDR_W(3), .ERR_CNT_W(16)) a_if ();
    fifo_wptr_ctrl_if #(.ADDR_W(3), .ERR_CNT_W(16)) b_if ();

    fifo_wptr_ctrl #(
        .ADDR_W(3), .PTR_CODE(PTR_GRAY), .AFULL_TH(6), .CHECK_HAMMING(1), .ERR_CNT_W(16)
    ) dut_a (
        .w_clk_i (clk),
        .w_rstn_i(rstn_a),
        .bus     (a_if.slave)
    );

    fifo_wptr_ctrl #(
        .ADDR_W(3), .PTR_CODE(PTR_BIN), .AFULL_TH(6), .CHECK_HAMMING(1), .ERR_CNT_W(16)
    ) dut_b (
        .w_clk_i (clk),
        .w_rstn_i(rstn_b),
        .bus     (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input int rdy, input int we, input int waddr, input int ptr,
                                input int lvl, input int full, input int af, input int ovf,
                                input int err, input int cnt);
        obs_t o;
        o.rdy   = 1'(rdy);
        o.we    = 1'(we);
        o.waddr = 3'(waddr);
        o.ptr   = 4'(ptr);
        o.lvl   = 4'(lvl);
        o.full  = 1'(full);
        o.af    = 1'(af);
        o.ovf   = 1'(ovf);
        o.err   = 1'(err);
        o.cnt   = 16'(cnt);
        return o;
    endfunction

    function automatic obs_t sample(input bit d);
        obs_t o;
        if (!d) begin
            o = {a_if.w_ready_o, a_if.mem_we_o, a_if.mem_waddr_o, a_if.w_ptr_o, a_if.w_level_o,
                 a_if.w_full_o, a_if.w_almost_full_o, a_if.w_overflow_o, a_if.w_ptr_err_o,
                 a_if.w_err_cnt_o};
        end else begin
            o = {b_if.w_ready_o, b_if.mem_we_o, b_if.mem_waddr_o, b_if.w_ptr_o, b_if.w_level_o,
                 b_if.w_full_o, b_if.w_almost_full_o, b_if.w_overflow_o, b_if.w_ptr_err_o,
                 b_if.w_err_cnt_o};
        end
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("rdy=%b we=%b waddr=%0d ptr=%h lvl=%0d full=%b af=%b ovf=%b err=%b cnt=%0d",
                         o.rdy, o.we, o.waddr, o.ptr, o.lvl, o.full, o.af, o.ovf, o.err, o.cnt);
    endfunction

    // One cycle: apply inputs to one instance after the rising edge, queue what it must show.
    task automatic drive(input bit d, input logic rst, input logic v, input int r,
                         input string name, input obs_t e);
        item_t it;
        @(posedge clk);
        #1;
        if (!d) begin
            rstn_a            = rst;
            a_if.w_valid_i    = v;
            a_if.r_ptr_sync_i = 4'(r);
        end else begin
            rstn_b            = rst;
            b_if.w_valid_i    = v;
            b_if.r_ptr_sync_i = 4'(r);
        end
        it.dut  = d;
        it.name = name;
        it.exp  = e;
        q.push_back(it);
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        rstn_a            = 1'b0;
        rstn_b            = 1'b0;
        a_if.w_valid_i    = 1'b0;
        a_if.r_ptr_sync_i = '0;
        b_if.w_valid_i    = 1'b0;
        b_if.r_ptr_sync_i = '0;

        // Monitor: compare one queued expectation per falling edge.
        fork
            forever begin
                item_t it;
                obs_t  act;
                @(negedge clk);
                if (q.size() != 0) begin
                    it  = q.pop_front();
                    act = sample(it.dut);
                    total++;
                    if (act !== it.exp) begin
                        bad++;
                        $display("FAIL %s dut%0d: got %s | want %s",
                                 it.name, it.dut, fmt(act), fmt(it.exp));
                    end
                end
            end
        join_none

        // Reset with a pending write, then 9 back-to-back writes into an empty FIFO.
        drive(0, 0, 1, 0, "reset",        mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(0, 1, 1, 0, "rel_first_wr", mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 2; k <= 9; k++) begin
            drive(0, 1, 1, 0, $sformatf("burst%0d", k),
                  mk((k == 9) ? 0 : 1, (k == 9) ? 0 : 1, (k - 1) % 8, G[k - 1], k - 1,
                     (k == 9) ? 1 : 0, (k >= 7) ? 1 : 0, 0, 0, 0));
        end
        drive(0, 1, 0, 0, "ovf_pulse",   mk(0, 0, 0, 12, 8, 1, 1, 1, 0, 0));

        // Read progress releases full one cycle later; a single write refills.
        drive(0, 1, 0, 1, "full_hold",   mk(0, 0, 0, 12, 8, 1, 1, 0, 0, 0));
        drive(0, 1, 1, 1, "rd_progress", mk(1, 1, 0, 12, 7, 0, 1, 0, 0, 0));
        drive(0, 1, 0, 1, "refull",      mk(0, 0, 1, 13, 8, 1, 1, 0, 0, 0));
        drive(0, 1, 1, 3, "full_blk",    mk(0, 0, 1, 13, 8, 1, 1, 0, 0, 0));
        drive(0, 1, 1, 2, "resume",      mk(1, 1, 1, 13, 7, 0, 1, 1, 0, 0));

        // Wrap: 20 writes with one legal gray read step per cycle, level steady at 7.
        for (int k = 16; k <= 35; k++) begin
            drive(0, 1, (k <= 34) ? 1'b1 : 1'b0, G[(k - 12) % 16], $sformatf("wrap%0d", k),
                  mk(1, (k <= 34) ? 1 : 0, (k - 6) % 8, G[(k - 6) % 16], 7, 0, 1, 0, 0, 0));
        end
        drive(0, 1, 0, 4, "idle",        mk(1, 0, 5, 11, 6, 0, 1, 0, 0, 0));

        // Gray corruption: two-bit jumps 0100->0111 and back, each counted once.
        drive(0, 1, 0, 7, "gray_jump",   mk(1, 0, 5, 11, 6, 0, 1, 0, 0, 0));
        drive(0, 1, 0, 7, "gray_err1",   mk(0, 0, 5, 11, 8, 1, 1, 0, 1, 1));
        drive(0, 1, 0, 4, "err_hold",    mk(0, 0, 5, 11, 8, 1, 1, 0, 1, 1));
        drive(0, 1, 0, 4, "gray_err2",   mk(1, 0, 5, 11, 6, 0, 1, 0, 1, 2));
        drive(0, 1, 0, 4, "err_sticky",  mk(1, 0, 5, 11, 6, 0, 1, 0, 1, 2));

        // Binary instance: read pointer ahead of write pointer, then reset mid-burst.
        drive(1, 1, 1, 0, "b_start",     mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(1, 1, 1, 0, "b_wr1",       mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0));
        drive(1, 1, 0, 5, "b_rd_ahead",  mk(1, 0, 2, 2, 2, 0, 0, 0, 0, 0));
        drive(1, 1, 1, 5, "b_err1",      mk(0, 0, 2, 2, 8, 1, 1, 0, 1, 1));
        drive(1, 1, 1, 5, "b_err2",      mk(0, 0, 2, 2, 8, 1, 1, 1, 1, 2));
        drive(1, 0, 1, 5, "b_mid_rst",   mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(1, 1, 1, 0, "b_rst_rel",   mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(1, 1, 0, 0, "b_restart",   mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
